// File: rtl/reg_file.sv
// Architectural register file: R0-R14 stored, R15 reads return the external PC+8.
// Three combinational read ports with write-through bypass, one synchronous write port.
module reg_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [3:0]   wa,
    input  logic [N-1:0] wd,
    input  logic [3:0]   a1,
    input  logic [3:0]   a2,
    input  logic [3:0]   a3,
    input  logic [N-1:0] r15,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    output logic [N-1:0] rd3
);

    logic [N-1:0] regs_q [15];
    logic [N-1:0] regs_d [15];
    logic [14:0]  wr_en;

    always_comb begin
        for (int i = 0; i < 15; i++) begin
            wr_en[i]  = we && (wa == 4'(i));
            regs_d[i] = wr_en[i] ? wd : regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Address 15 is the PC and wins over reset; the bypass is suppressed during reset.
    function automatic logic [N-1:0] read_port(
        input logic [3:0]   addr,
        input logic         rst,
        input logic         wen,
        input logic [3:0]   waddr,
        input logic [N-1:0] wdata,
        input logic [N-1:0] pc,
        input logic [N-1:0] stored
    );
        logic [N-1:0] data;
        data = stored;
        if (addr == 4'hF) begin
            data = pc;
        end else if (rst) begin
            data = '0;
        end else if (wen && (waddr == addr)) begin
            data = wdata;
        end
        return data;
    endfunction

    logic [N-1:0] stored1, stored2, stored3;

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        stored3 = '0;
        for (int i = 0; i < 15; i++) begin
            if (a1 == 4'(i)) stored1 = regs_q[i];
            if (a2 == 4'(i)) stored2 = regs_q[i];
            if (a3 == 4'(i)) stored3 = regs_q[i];
        end
    end

    assign rd1 = read_port(a1, reset, we, wa, wd, r15, stored1);
    assign rd2 = read_port(a2, reset, we, wa, wd, r15, stored2);
    assign rd3 = read_port(a3, reset, we, wa, wd, r15, stored3);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read data into a queue,
// a monitor process pops and compares against the DUT ports.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  wa, a1, a2, a3;
    logic [31:0] wd, r15;
    logic [31:0] rd1, rd2, rd3;
    logic [15:0] rd1_16, rd2_16, rd3_16;

    always #5 clk = ~clk;

    reg_file #(.N(32)) u_dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .a1(a1), .a2(a2), .a3(a3), .r15(r15),
        .rd1(rd1), .rd2(rd2), .rd3(rd3)
    );

    reg_file #(.N(16)) u_dut16 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd[15:0]),
        .a1(a1), .a2(a2), .a3(a3), .r15(r15[15:0]),
        .rd1(rd1_16), .rd2(rd2_16), .rd3(rd3_16)
    );

    typedef struct {
        string       name;
        logic [31:0] e1, e2, e3;
        bit          c1, c2, c3;
        bit          w16;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic cmp(input string nm, input string port, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h at %0t", nm, port, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.c1) cmp(e.name, "rd1", e.w16 ? {16'h0, rd1_16} : rd1, e.e1);
                if (e.c2) cmp(e.name, "rd2", e.w16 ? {16'h0, rd2_16} : rd2, e.e2);
                if (e.c3) cmp(e.name, "rd3", e.w16 ? {16'h0, rd3_16} : rd3, e.e3);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] e3, input bit c1, input bit c2, input bit c3,
                       input bit w16);
        exp_t e;
        #1;
        e.name = nm; e.e1 = e1; e.e2 = e2; e.e3 = e3;
        e.c1 = c1; e.c2 = c2; e.c3 = c3; e.w16 = w16;
        sb_q.push_back(e);
        ->chk_ev;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wa = 4'd0; wd = '0;
        a1 = 4'd0; a2 = 4'd7; a3 = 4'd14; r15 = 32'h0000_0108;
        #12;
        chk("reset_state", 32'h0, 32'h0, 32'h0, 1, 1, 1, 0);
        a1 = 4'd15;
        chk("reset_r15", 32'h0000_0108, 32'h0, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // asynchronous clear in the middle of a cycle
        wr(4'd3, 32'hDEAD_BEEF);
        a1 = 4'd3;
        chk("pre_reset_r3", 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 0, 0, 0);
        #1 reset = 1'b1;
        chk("async_clear", 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("after_release", 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        @(posedge clk);
        chk("after_release_edge", 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);

        for (int i = 0; i < 15; i++) wr(4'(i), 32'h1000_0000 + i);
        for (int i = 0; i < 15; i++) begin
            a1 = 4'(i); a2 = 4'(i); a3 = 4'(i);
            chk("readback_same", 32'h1000_0000 + i, 32'h1000_0000 + i, 32'h1000_0000 + i,
                1, 1, 1, 0);
        end
        for (int i = 0; i < 15; i++) begin
            a1 = 4'(i); a2 = 4'((i + 5) % 15); a3 = 4'((i + 10) % 15);
            chk("readback_mixed", 32'h1000_0000 + i, 32'h1000_0000 + ((i + 5) % 15),
                32'h1000_0000 + ((i + 10) % 15), 1, 1, 1, 0);
        end

        // R15 reads come from the r15 input, writes to 15 are dropped
        @(negedge clk);
        r15 = 32'h0000_0108; we = 1'b1; wa = 4'd15; wd = 32'hFFFF_FFFF;
        a1 = 4'd15; a2 = 4'd15; a3 = 4'd15;
        chk("r15_read", 32'h0000_0108, 32'h0000_0108, 32'h0000_0108, 1, 1, 1, 0);
        r15 = 32'h0000_010C;
        chk("r15_change", 32'h0000_010C, 32'h0000_010C, 32'h0000_010C, 1, 1, 1, 0);
        @(posedge clk);
        #1 we = 1'b0;
        for (int i = 0; i < 15; i++) begin
            a1 = 4'(i);
            chk("r15_no_side_effect", 32'h1000_0000 + i, 32'h0, 32'h0, 1, 0, 0, 0);
        end

        // write-through bypass
        wr(4'd5, 32'h11);
        @(negedge clk);
        we = 1'b1; wa = 4'd5; wd = 32'h22; a1 = 4'd5; a2 = 4'd6;
        chk("bypass", 32'h22, 32'h1000_0006, 32'h0, 1, 1, 0, 0);
        @(posedge clk);
        #1 we = 1'b0;
        chk("bypass_stored", 32'h22, 32'h1000_0006, 32'h0, 1, 1, 0, 0);

        // back-to-back writes: second write visible via bypass, then stored
        @(negedge clk);
        we = 1'b1; wa = 4'd9; wd = 32'hA1; a1 = 4'd9;
        @(posedge clk);
        #1 wd = 32'hB2;
        chk("b2b_bypass", 32'hB2, 32'h0, 32'h0, 1, 0, 0, 0);
        @(posedge clk);
        #1 we = 1'b0;
        chk("b2b_last_wins", 32'hB2, 32'h0, 32'h0, 1, 0, 0, 0);

        // reset and write at the same edge
        @(negedge clk);
        reset = 1'b1; we = 1'b1; wa = 4'd7; wd = 32'h55; a3 = 4'd7;
        chk("collision_no_bypass", 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        @(posedge clk);
        chk("collision_r7", 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        @(negedge clk);
        we = 1'b0; reset = 1'b0;
        chk("collision_after_release", 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        wr(4'd7, 32'h55);
        chk("collision_rewrite", 32'h0, 32'h0, 32'h55, 0, 0, 1, 0);

        // narrow instance
        wr(4'd14, 32'h0000_ABCD);
        r15 = 32'h1234_5678;
        a1 = 4'd14; a2 = 4'd15; a3 = 4'd7;
        chk("n16", 32'hABCD, 32'h5678, 32'h0055, 1, 1, 1, 1);
        chk("n32_r14", 32'h0000_ABCD, 32'h1234_5678, 32'h55, 1, 1, 1, 0);

        #5;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
